// File: rtl/noc_resp_tx.sv
// NoC transmit side: serialises READ/WRITE RESPONSE packets one byte per clock from a 64-bit word FIFO.
// Optional protocol checking (sticky err) is enabled by defining NOC_TX_CHK_EN.
module noc_resp_tx #(
    parameter int FIFO_DEPTH  = 16,
    parameter int STOP_MARGIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic        rsp_op,
    input  logic [1:0]  rsp_rc,
    input  logic [2:0]  rsp_dlen,
    input  logic [7:0]  rsp_dest,
    input  logic [7:0]  rsp_src,
    input  logic        pushout,
    input  logic        firstout,
    input  logic [63:0] dout,
    output logic        stopout,
    output logic        noc_from_dev_ctl,
    output logic [7:0]  noc_from_dev_data,
    output logic        err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef NOC_TX_CHK_EN
    localparam int MW = 65;
`else
    localparam int MW = 64;
`endif
    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(STOP_MARGIN);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CMD  = 3'd1;
    localparam logic [2:0] ST_DEST = 3'd2;
    localparam logic [2:0] ST_SRC  = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;

    function automatic logic [4:0] words_needed(input logic [2:0] dlen);
        logic [4:0] w;
        case (dlen)
            3'd4:    w = 5'd2;
            3'd5:    w = 5'd4;
            3'd6:    w = 5'd8;
            3'd7:    w = 5'd16;
            default: w = 5'd1;
        endcase
        return w;
    endfunction

    function automatic logic [6:0] last_byte(input logic [2:0] dlen);
        return 7'((8'd1 << dlen) - 8'd1);
    endfunction

    logic [MW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic [MW-1:0] head_s;
    logic [7:0]    head_byte_s;
    logic [6:0]    last_idx_s;

    logic [2:0]    state;
    logic [2:0]    dlen_r;
    logic          op_r;
    logic [7:0]    dest_r;
    logic [7:0]    src_r;
    logic [6:0]    byte_cnt;
    logic [2:0]    byte_idx;

    assign head_s      = mem[rd_ptr];
    assign head_byte_s = head_s[{byte_idx, 3'b000} +: 8];

    // FIFO control, pop decision and descriptor acceptance
    always_comb begin
        full_s       = (count == DEPTH_C);
        push_s       = pushout & ~full_s;
        last_idx_s   = last_byte(dlen_r);
        pop_s        = 1'b0;
        count_next_s = count;
        rsp_ready    = 1'b0;
        // a word leaves the FIFO when its byte 7 or the packet's last byte is loaded
        if (state == ST_SRC) begin
            pop_s = ~op_r & (last_idx_s == 7'd0);
        end else if (state == ST_DATA) begin
            pop_s = (byte_cnt != last_idx_s) &
                    ((byte_idx == 3'd7) | ((byte_cnt + 7'd1) == last_idx_s));
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count + CW'(1);
            2'b01:   count_next_s = count - CW'(1);
            default: count_next_s = count;
        endcase
        if (~reset && (state == ST_IDLE)) begin
            rsp_ready = rsp_op | (32'(count) >= 32'(words_needed(rsp_dlen)));
        end else begin
            rsp_ready = 1'b0;
        end
    end

    // FIFO pointers, occupancy and registered backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            stopout <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_s) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
            count   <= count_next_s;
            stopout <= ((DEPTH_C - count_next_s) <= MARGIN_C);
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
`ifdef NOC_TX_CHK_EN
            mem[wr_ptr] <= {firstout, dout};
`else
            mem[wr_ptr] <= dout;
`endif
        end
    end

    // Packet FSM; the output registers always hold the byte for the current state
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            op_r              <= 1'b0;
            dlen_r            <= 3'd0;
            dest_r            <= 8'h00;
            src_r             <= 8'h00;
            byte_cnt          <= 7'd0;
            byte_idx          <= 3'd0;
            noc_from_dev_ctl  <= 1'b1;
            noc_from_dev_data <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    noc_from_dev_ctl <= 1'b1;
                    if (rsp_valid && rsp_ready) begin
                        op_r   <= rsp_op;
                        dlen_r <= rsp_op ? 3'd0 : rsp_dlen;
                        dest_r <= rsp_dest;
                        src_r  <= rsp_src;
                        noc_from_dev_data <= rsp_op ? {rsp_rc, 3'b000, 3'b100}
                                                    : {rsp_rc, rsp_dlen, 3'b011};
                        state  <= ST_CMD;
                    end else begin
                        noc_from_dev_data <= 8'h00;
                    end
                end
                ST_CMD: begin
                    noc_from_dev_ctl  <= 1'b0;
                    noc_from_dev_data <= dest_r;
                    state             <= ST_DEST;
                end
                ST_DEST: begin
                    noc_from_dev_ctl  <= 1'b0;
                    noc_from_dev_data <= src_r;
                    state             <= ST_SRC;
                end
                ST_SRC: begin
                    if (op_r) begin
                        noc_from_dev_ctl  <= 1'b1;
                        noc_from_dev_data <= 8'h00;
                        state             <= ST_IDLE;
                    end else begin
                        noc_from_dev_ctl  <= 1'b0;
                        noc_from_dev_data <= head_byte_s;
                        byte_idx          <= byte_idx + 3'd1;
                        byte_cnt          <= 7'd0;
                        state             <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_cnt == last_idx_s) begin
                        noc_from_dev_ctl  <= 1'b1;
                        noc_from_dev_data <= 8'h00;
                        byte_cnt          <= 7'd0;
                        byte_idx          <= 3'd0;
                        state             <= ST_IDLE;
                    end else begin
                        noc_from_dev_ctl  <= 1'b0;
                        noc_from_dev_data <= head_byte_s;
                        byte_cnt          <= byte_cnt + 7'd1;
                        byte_idx          <= byte_idx + 3'd1;
                    end
                end
                default: begin
                    noc_from_dev_ctl  <= 1'b1;
                    noc_from_dev_data <= 8'h00;
                    state             <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef NOC_TX_CHK_EN
    logic first_pop_r;

    // Protocol checker: overflow and firstout framing of popped words
    always_ff @(posedge clk) begin
        if (reset) begin
            err         <= 1'b0;
            first_pop_r <= 1'b0;
        end else begin
            if ((pushout && full_s) ||
                (pop_s && first_pop_r && !head_s[64]) ||
                (pop_s && !first_pop_r && head_s[64])) begin
                err <= 1'b1;
            end
            if ((state == ST_IDLE) && rsp_valid && rsp_ready) begin
                first_pop_r <= 1'b1;
            end else if (pop_s) begin
                first_pop_r <= 1'b0;
            end
        end
    end
`else
    logic unused_firstout_s;
    assign unused_firstout_s = firstout;

    // Checking disabled: err held low
    always_ff @(posedge clk) begin
        err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_noc_resp_tx.sv
// Self-checking bench for noc_resp_tx: directed scenarios plus randomized packets against a byte-stream model.
module tb_noc_resp_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_op;
    logic [1:0]  rsp_rc;
    logic [2:0]  rsp_dlen;
    logic [7:0]  rsp_dest;
    logic [7:0]  rsp_src;
    logic        pushout;
    logic        firstout;
    logic [63:0] dout;
    logic        stopout;
    logic        ctl;
    logic [7:0]  data;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef NOC_TX_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    noc_resp_tx #(.FIFO_DEPTH(16), .STOP_MARGIN(2)) dut (
        .clk(clk), .reset(reset), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_op(rsp_op), .rsp_rc(rsp_rc), .rsp_dlen(rsp_dlen), .rsp_dest(rsp_dest),
        .rsp_src(rsp_src), .pushout(pushout), .firstout(firstout), .dout(dout),
        .stopout(stopout), .noc_from_dev_ctl(ctl), .noc_from_dev_data(data), .err(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; rsp_valid = 1'b0; pushout = 1'b0; firstout = 1'b0; dout = '0;
        rsp_op = 1'b0; rsp_rc = 2'd0; rsp_dlen = 3'd0; rsp_dest = 8'h00; rsp_src = 8'h00;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [63:0] w, input logic f);
        pushout = 1'b1; dout = w; firstout = f;
        step();
        pushout = 1'b0;
    endtask

    // returns at the cycle where the command byte is on the wire
    task automatic send_desc(input logic op, input logic [1:0] rc, input logic [2:0] dlen,
                             input logic [7:0] dest, input logic [7:0] src);
        bit ok = 1'b0;
        rsp_op = op; rsp_rc = rc; rsp_dlen = dlen; rsp_dest = dest; rsp_src = src;
        rsp_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            #1;
            if (rsp_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        rsp_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL handshake: rsp_ready got 0 for 300 cycles, want 1");
        end
    endtask

    // samples {ctl,data} each cycle; drops rsp_valid after any handshake it sees
    task automatic capture(input int n, output logic [8:0] got[$]);
        bit hs;
        got = {};
        for (int i = 0; i < n; i++) begin
            got.push_back({ctl, data});
            #1;
            hs = rsp_valid && rsp_ready;
            @(posedge clk);
            #1;
            if (hs) rsp_valid = 1'b0;
        end
    endtask

    // reference: the byte stream of one packet followed by one NOP
    function automatic void build_pkt(input logic op, input logic [1:0] rc, input logic [2:0] dlen,
                                      input logic [7:0] dest, input logic [7:0] src,
                                      input logic [63:0] words[$], output logic [8:0] e[$]);
        int c;
        int nbytes;
        logic [63:0] w;
        e = {};
        c = op ? (rc * 64 + 4) : (rc * 64 + dlen * 8 + 3);
        e.push_back({1'b1, c[7:0]});
        e.push_back({1'b0, dest});
        e.push_back({1'b0, src});
        if (!op) begin
            nbytes = 1 << dlen;
            for (int i = 0; i < nbytes; i++) begin
                w = words[i / 8];
                w = w >> (8 * (i % 8));
                e.push_back({1'b0, w[7:0]});
            end
        end
        e.push_back({1'b1, 8'h00});
    endfunction

    task automatic test_reset();
        reset = 1'b1; rsp_valid = 1'b0; pushout = 1'b0; rsp_op = 1'b1;
        step();
        n_checks++;
        if ({ctl, data} !== 9'h100) $display("FAIL reset_nop: got %h want 100", {ctl, data}); else n_pass++;
        n_checks++;
        if (stopout !== 1'b0) $display("FAIL reset_stopout: got %b want 0", stopout); else n_pass++;
        n_checks++;
        if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++;
        if (rsp_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", rsp_ready); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (rsp_ready !== 1'b1) $display("FAIL idle_write_ready: got %b want 1", rsp_ready); else n_pass++;
        rsp_op = 1'b0;
    endtask

    task automatic test_write_resp();
        logic [8:0] got[$];
        logic [8:0] e[$];
        int bad = -1;
        do_reset();
        e = {9'h104, 9'h012, 9'h034, 9'h100};
        send_desc(1'b1, 2'd0, 3'd0, 8'h12, 8'h34);
        capture(e.size(), got);
        for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL write_pkt: cycle %0d got %h want %h", bad, got[bad], e[bad]); else n_pass++;
    endtask

    task automatic test_read_resp();
        logic [8:0] got[$];
        logic [8:0] e[$];
        int bad = -1;
        do_reset();
        push_word(64'h0807060504030201, 1'b1);
        e = {9'h15B, 9'h0A0, 9'h005, 9'h001, 9'h002, 9'h003, 9'h004,
             9'h005, 9'h006, 9'h007, 9'h008, 9'h100};
        send_desc(1'b0, 2'd1, 3'd3, 8'hA0, 8'h05);
        capture(e.size(), got);
        for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL read_pkt: cycle %0d got %h want %h", bad, got[bad], e[bad]); else n_pass++;
    endtask

    task automatic test_dlen7_ready();
        logic [63:0] words[$];
        logic [8:0] got[$];
        logic [8:0] e[$];
        int bad = -1;
        bit seen = 1'b0;
        do_reset();
        for (int k = 0; k < 16; k++) words.push_back({$urandom, $urandom});
        for (int k = 0; k < 15; k++) push_word(words[k], k == 0);
        rsp_op = 1'b0; rsp_rc = 2'd2; rsp_dlen = 3'd7; rsp_dest = 8'h55; rsp_src = 8'hAA;
        rsp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rsp_ready) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL ready_15_words: got 1 want 0"); else n_pass++;
        pushout = 1'b1; dout = words[15]; firstout = 1'b0;
        step();
        pushout = 1'b0;
        #1;
        n_checks++;
        if (rsp_ready !== 1'b1) $display("FAIL ready_16_words: got %b want 1", rsp_ready); else n_pass++;
        step();
        rsp_valid = 1'b0;
        build_pkt(1'b0, 2'd2, 3'd7, 8'h55, 8'hAA, words, e);
        capture(e.size(), got);
        for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL dlen7_pkt: cycle %0d got %h want %h", bad, got[bad], e[bad]); else n_pass++;
    endtask

    task automatic test_stopout();
        logic [63:0] words[$];
        logic [8:0] got[$];
        logic [8:0] e[$];
        int bad = -1;
        do_reset();
        for (int k = 0; k < 16; k++) words.push_back({$urandom, $urandom});
        for (int k = 0; k < 13; k++) push_word(words[k], k == 0);
        n_checks++;
        if (stopout !== 1'b0) $display("FAIL stopout_13: got %b want 0", stopout); else n_pass++;
        push_word(words[13], 1'b0);
        n_checks++;
        if (stopout !== 1'b1) $display("FAIL stopout_14: got %b want 1", stopout); else n_pass++;
        push_word(words[14], 1'b0);
        push_word(words[15], 1'b0);
        push_word(64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        n_checks++;
        if (err !== CHK) $display("FAIL overflow_err: got %b want %b", err, CHK); else n_pass++;
        send_desc(1'b0, 2'd3, 3'd7, 8'h01, 8'h02);
        build_pkt(1'b0, 2'd3, 3'd7, 8'h01, 8'h02, words, e);
        capture(e.size(), got);
        for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL overflow_pkt: cycle %0d got %h want %h", bad, got[bad], e[bad]); else n_pass++;
        n_checks++;
        if (stopout !== 1'b0) $display("FAIL stopout_drained: got %b want 0", stopout); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [8:0] got[$];
        logic [8:0] e[$];
        logic [8:0] e2[$];
        logic [63:0] none[$];
        int bad = -1;
        do_reset();
        build_pkt(1'b1, 2'd1, 3'd0, 8'h11, 8'h22, none, e);
        build_pkt(1'b1, 2'd2, 3'd0, 8'h33, 8'h44, none, e2);
        foreach (e2[i]) e.push_back(e2[i]);
        send_desc(1'b1, 2'd1, 3'd0, 8'h11, 8'h22);
        rsp_op = 1'b1; rsp_rc = 2'd2; rsp_dest = 8'h33; rsp_src = 8'h44; rsp_valid = 1'b1;
        capture(e.size(), got);
        rsp_valid = 1'b0;
        for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL back_to_back: cycle %0d got %h want %h", bad, got[bad], e[bad]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] words[$];
        logic [8:0] got[$];
        logic [8:0] e[$];
        int bad = -1;
        do_reset();
        push_word(64'h1111_2222_3333_4444, 1'b1);
        push_word(64'h5555_6666_7777_8888, 1'b0);
        send_desc(1'b0, 2'd0, 3'd4, 8'h99, 8'h88);
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({ctl, data} !== 9'h100) $display("FAIL reset_mid_nop: got %h want 100", {ctl, data}); else n_pass++;
        rsp_op = 1'b0; rsp_dlen = 3'd0;
        #1;
        n_checks++;
        if (rsp_ready !== 1'b0) $display("FAIL reset_mid_empty: ready got %b want 0", rsp_ready); else n_pass++;
        step();
        n_checks++;
        if ({ctl, data} !== 9'h100) $display("FAIL reset_mid_idle: got %h want 100", {ctl, data}); else n_pass++;
        words.push_back(64'h0000_0000_0000_00C3);
        push_word(words[0], 1'b1);
        send_desc(1'b0, 2'd1, 3'd0, 8'h01, 8'h02);
        build_pkt(1'b0, 2'd1, 3'd0, 8'h01, 8'h02, words, e);
        capture(e.size(), got);
        for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL after_reset_pkt: cycle %0d got %h want %h", bad, got[bad], e[bad]); else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] words[$];
        logic [8:0] got[$];
        logic [8:0] e[$];
        logic op;
        logic [1:0] rc;
        logic [2:0] dlen;
        logic [7:0] dest;
        logic [7:0] src;
        int nw;
        int bad;
        do_reset();
        for (int it = 0; it < 20; it++) begin
            op   = 1'($urandom_range(0, 1));
            rc   = 2'($urandom_range(0, 3));
            dlen = 3'($urandom_range(0, 7));
            dest = 8'($urandom);
            src  = 8'($urandom);
            words = {};
            nw = op ? 0 : ((dlen < 3) ? 1 : (1 << (dlen - 3)));
            for (int k = 0; k < nw; k++) begin
                words.push_back({$urandom, $urandom});
                push_word(words[k], k == 0);
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
            send_desc(op, rc, dlen, dest, src);
            build_pkt(op, rc, dlen, dest, src, words, e);
            capture(e.size(), got);
            bad = -1;
            for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
            n_checks++;
            if (bad >= 0) $display("FAIL random_pkt %0d (op %0d dlen %0d): cycle %0d got %h want %h",
                                   it, op, dlen, bad, got[bad], e[bad]);
            else n_pass++;
        end
        n_checks++;
        if (err !== 1'b0) $display("FAIL random_err: got %b want 0", err); else n_pass++;
    endtask

    task automatic test_err();
        logic [63:0] words[$];
        logic [8:0] got[$];
        logic [8:0] e[$];
        int bad = -1;
        do_reset();
        words.push_back(64'h8877_6655_4433_2211);
        push_word(words[0], 1'b0);
        n_checks++;
        if (err !== 1'b0) $display("FAIL err_before_pop: got %b want 0", err); else n_pass++;
        send_desc(1'b0, 2'd0, 3'd3, 8'h0F, 8'hF0);
        build_pkt(1'b0, 2'd0, 3'd3, 8'h0F, 8'hF0, words, e);
        capture(e.size(), got);
        for (int i = 0; i < e.size(); i++) if (bad < 0 && got[i] !== e[i]) bad = i;
        n_checks++;
        if (bad >= 0) $display("FAIL err_pkt: cycle %0d got %h want %h", bad, got[bad], e[bad]); else n_pass++;
        n_checks++;
        if (err !== CHK) $display("FAIL err_set: got %b want %b", err, CHK); else n_pass++;
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (err !== CHK) $display("FAIL err_sticky: got %b want %b", err, CHK); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; rsp_valid = 1'b0; pushout = 1'b0; firstout = 1'b0; dout = '0;
        rsp_op = 1'b0; rsp_rc = 2'd0; rsp_dlen = 3'd0; rsp_dest = 8'h00; rsp_src = 8'h00;
        step();
        test_reset();
        test_write_resp();
        test_read_resp();
        test_dlen7_ready();
        test_stopout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_err();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
